// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding,
// default widths, requester indices and a small counter helper.
package dmem_arb_pkg;

    // Default port widths
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    // Requester indices into the gnt vector
    localparam int REQ_PROTO = 0;   // protocol controller
    localparam int REQ_DUMP  = 1;   // UART data-memory dump engine

    // Arbiter state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    typedef logic [1:0] arb_state_t;

    // Increment that sticks at the limit instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value >= limit) ? limit : value + 8'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Pure combinational grant selector: sticky round-robin with a burst limit.
// Produces a one-hot (or all-zero) grant from the request pair and the
// arbiter's current ownership state.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic [1:0] req,
    input  logic [1:0] state,
    input  logic       last,
    input  logic [7:0] burst_cnt,
    output logic [1:0] gnt
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    // Choose the winner; contention is resolved by owner stickiness, then burst limit, then last
    always_comb begin
        // NOTE: gnt gets a default before the case so every path assigns it and no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                case (state)
                    OWN0:    gnt = (burst_cnt < MAX_B) ? 2'b01 : 2'b10;
                    OWN1:    gnt = (burst_cnt < MAX_B) ? 2'b10 : 2'b01;
                    // No owner: the requester that did not win last time goes first
                    default: gnt = last ? 2'b01 : 2'b10;
                endcase
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single datamem controller port between the protocol controller
// (requester 0) and the UART dump engine (requester 1). Holds the ownership
// registers, the same-cycle port mux and the 1-cycle read-tag pipeline.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    // Requester 0: protocol controller
    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W/8-1:0]   m0_wr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    // Requester 1: UART dump engine
    input  logic                  m1_req,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W/8-1:0]   m1_wr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    // Datamem controller port
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int         BE_W  = DATA_W / 8;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    arb_state_t state;
    logic       last;
    logic [7:0] burst_cnt;
    logic       pend0;
    logic       pend1;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       same_owner;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req       ({m1_req, m0_req}),
        .state     (state),
        .last      (last),
        .burst_cnt (burst_cnt),
        .gnt       (pick_gnt)
    );

    // Nothing is accepted while reset is asserted, which also keeps writes off the port
    assign gnt    = rst ? 2'b00 : pick_gnt;
    assign m0_gnt = gnt[REQ_PROTO];
    assign m1_gnt = gnt[REQ_DUMP];

    assign same_owner = (gnt[REQ_PROTO] && (state == OWN0)) ||
                        (gnt[REQ_DUMP]  && (state == OWN1));

    // Route the granted requester onto the memory port; idle port is all zeros
    always_comb begin
        mem_addr  = '0;
        mem_write = '0;
        mem_wdata = '0;
        if (gnt[REQ_PROTO]) begin
            mem_addr  = m0_addr;
            mem_write = m0_wr;
            mem_wdata = m0_wdata;
        end else if (gnt[REQ_DUMP]) begin
            mem_addr  = m1_addr;
            mem_write = m1_wr;
            mem_wdata = m1_wdata;
        end
    end

    // Ownership, round-robin history, burst counter and read tags
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= 8'd0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
        end else begin
            // A granted read tags its requester for the data returning next cycle
            pend0 <= gnt[REQ_PROTO] && (m0_wr == BE_W'(0));
            pend1 <= gnt[REQ_DUMP]  && (m1_wr == BE_W'(0));
            if (gnt == 2'b00) begin
                state     <= IDLE;
                burst_cnt <= 8'd0;
            end else if (same_owner) begin
                burst_cnt <= sat_inc(burst_cnt, MAX_B);
            end else begin
                state     <= gnt[REQ_DUMP] ? OWN1 : OWN0;
                last      <= gnt[REQ_DUMP];
                burst_cnt <= 8'd1;
            end
        end
    end

    // Read data is broadcast; the per-requester rvalid says whose it is
    assign m0_rvalid = pend0;
    assign m1_rvalid = pend1;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule
